riscv_alu_wb: RTL

RISCV_ALU_WB -- requirements
Module: riscv_alu_wb

---
 rtl/riscv_alu_wb_if.sv | 31 +++
 rtl/riscv_alu_wb.sv | 86 ++++++++
 2 files changed

// File: rtl/riscv_alu_wb_if.sv
// Bundle of the ALU-result input handshake, register-file write port,
// forwarding view and retirement counters of the riscv_alu_wb writeback buffer.
interface riscv_alu_wb_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rd;
    logic [DATA_W-1:0] in_result;
    logic              rf_ready;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [31:0]       retired;
    logic [31:0]       dropped;

    modport master (
        output in_valid, in_rd, in_result, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata,
        input  fwd_valid, fwd_rd, fwd_data, retired, dropped
    );

    modport slave (
        input  in_valid, in_rd, in_result, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata,
        output fwd_valid, fwd_rd, fwd_data, retired, dropped
    );
endinterface

// File: rtl/riscv_alu_wb.sv
// Two-entry writeback buffer between the ALU and the register file, with x0 filtering.
// Define RISCV_WB_FWD_EN to compile in the youngest-entry forwarding view.
module riscv_alu_wb #(
    parameter int DATA_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    riscv_alu_wb_if.slave wb
);

    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              head_ptr;
    logic              wr_ptr;
    logic [4:0]        ent_rd   [2];
    logic [DATA_W-1:0] ent_data [2];
    logic [31:0]       retired_q;
    logic [31:0]       dropped_q;

    logic drain;
    logic in_ready;
    logic accept;
    logic push;
    logic rf_we;

    assign rf_we    = (cnt != 2'd0);
    assign drain    = rf_we && wb.rf_ready;
    assign in_ready = (cnt != 2'd2) || drain;
    assign accept   = wb.in_valid && in_ready;
    assign push     = accept && (wb.in_rd != 5'd0);
    // Slot after the current tail; when full and draining this is the slot being vacated.
    assign wr_ptr   = head_ptr ^ cnt[0];

    always_comb begin
        cnt_nxt = cnt;
        if (push && !drain)
            cnt_nxt = cnt + 2'd1;
        else if (!push && drain)
            cnt_nxt = cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            head_ptr  <= 1'b0;
            retired_q <= 32'd0;
            dropped_q <= 32'd0;
        end else begin
            cnt <= cnt_nxt;
            if (drain) begin
                head_ptr  <= ~head_ptr;
                retired_q <= retired_q + 32'd1;
            end
            if (accept && (wb.in_rd == 5'd0))
                dropped_q <= dropped_q + 32'd1;
        end
    end

    // Payload storage carries no reset; every read of it is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= wb.in_rd;
            ent_data[wr_ptr] <= wb.in_result;
        end
    end

    assign wb.in_ready = in_ready;
    assign wb.rf_we    = rf_we;
    assign wb.rf_waddr = rf_we ? ent_rd[head_ptr]   : 5'd0;
    assign wb.rf_wdata = rf_we ? ent_data[head_ptr] : '0;
    assign wb.retired  = retired_q;
    assign wb.dropped  = dropped_q;

`ifdef RISCV_WB_FWD_EN
    logic young_ptr;
    assign young_ptr    = head_ptr ^ (cnt == 2'd2);
    assign wb.fwd_valid = rf_we;
    assign wb.fwd_rd    = rf_we ? ent_rd[young_ptr]   : 5'd0;
    assign wb.fwd_data  = rf_we ? ent_data[young_ptr] : '0;
`else
    assign wb.fwd_valid = 1'b0;
    assign wb.fwd_rd    = 5'd0;
    assign wb.fwd_data  = '0;
`endif

endmodule
